// File: rtl/vga_line_feeder.sv
// vga_line_feeder: on each display line request, writes exactly H_ACTIVE RGB565 words from a
// ready/valid source, padding gaps with FILL_COLOR. Define VGA_FEEDER_BARS_EN for the colour-bar self-test.
module vga_line_feeder #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned V_ACTIVE   = 480,
  parameter logic [15:0] FILL_COLOR = 16'h0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [10:0] iTag,
  input  logic [15:0] iSrcData,
  input  logic        iSrcValid,
  output logic        oSrcReady,
  input  logic        iPatSel,
  input  logic        iClr,
  output logic        oEn,
  output logic [15:0] oData,
  output logic        oUnderflow,
  output logic        oOverrun
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_FILL = 2'd1,
    S_DONE = 2'd2
  } state_t;

  localparam logic [9:0]  LAST_WORD = 10'(H_ACTIVE - 1);
  localparam logic [10:0] Y_LIMIT   = 11'(V_ACTIVE);

  logic [10:0] r_tag_s1;
  logic [10:0] r_tag_s2;
  logic        r_req_s3;
  state_t      r_state;
  state_t      w_state_nxt;
  logic [9:0]  r_word_cnt;
  logic        r_en;
  logic [15:0] r_data;
  logic        r_underflow;
  logic        r_overrun;

  logic        w_req;
  logic        w_start;
  logic        w_ovr_set;
  logic        w_in_fill;
  logic        w_last;
  logic        w_bars;
  logic [15:0] w_word;
  logic        w_word_missing;

  // iTag is asynchronous; only bit 10 needs the extra stage for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tag_s1 <= '0;
      r_tag_s2 <= '0;
      r_req_s3 <= 1'b0;
    end else begin
      r_tag_s1 <= iTag;
      r_tag_s2 <= r_tag_s1;
      r_req_s3 <= r_tag_s2[10];
    end
  end

  assign w_req     = r_tag_s2[10] & ~r_req_s3;
  assign w_in_fill = (r_state == S_FILL);
  assign w_last    = (r_word_cnt == LAST_WORD);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_start     = 1'b0;
    w_ovr_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_req && ({1'b0, r_tag_s2[9:0]} < Y_LIMIT)) begin
          w_start     = 1'b1;
          w_state_nxt = S_FILL;
        end
      end
      S_FILL: begin
        w_ovr_set = w_req;
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        w_ovr_set   = w_req;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word_cnt <= '0;
    end else if (w_start) begin
      r_word_cnt <= '0;
    end else if (w_in_fill && !w_last) begin
      r_word_cnt <= r_word_cnt + 10'd1;
    end
  end

`ifdef VGA_FEEDER_BARS_EN
  localparam int unsigned BAR_W    = H_ACTIVE / 8;
  localparam logic [9:0]  BAR_LAST = (BAR_W == 0) ? 10'd0 : 10'(BAR_W - 1);
  localparam logic [3:0]  BAR_IDX0 = (BAR_W == 0) ? 4'd8 : 4'd0;

  logic        r_bars;
  logic [9:0]  r_bar_cnt;
  logic [3:0]  r_bar_idx;
  logic [15:0] w_bar_color;

  // Bar index tracked with a segment counter instead of dividing the word count;
  // index 8 covers the remainder words past the eighth bar.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bars    <= 1'b0;
      r_bar_cnt <= '0;
      r_bar_idx <= '0;
    end else if (w_start) begin
      r_bars    <= iPatSel;
      r_bar_cnt <= '0;
      r_bar_idx <= BAR_IDX0;
    end else if (w_in_fill && (r_bar_idx < 4'd8)) begin
      if (r_bar_cnt == BAR_LAST) begin
        r_bar_cnt <= '0;
        r_bar_idx <= r_bar_idx + 4'd1;
      end else begin
        r_bar_cnt <= r_bar_cnt + 10'd1;
      end
    end
  end

  always_comb begin
    w_bar_color = 16'h0000;
    case (r_bar_idx)
      4'd0:    w_bar_color = 16'hFFFF;
      4'd1:    w_bar_color = 16'hFFE0;
      4'd2:    w_bar_color = 16'h07FF;
      4'd3:    w_bar_color = 16'h07E0;
      4'd4:    w_bar_color = 16'hF81F;
      4'd5:    w_bar_color = 16'hF800;
      4'd6:    w_bar_color = 16'h001F;
      default: w_bar_color = 16'h0000;
    endcase
  end

  assign w_bars         = r_bars;
  assign w_word         = r_bars ? w_bar_color : (iSrcValid ? iSrcData : FILL_COLOR);
  assign w_word_missing = ~r_bars & ~iSrcValid;
`else
  logic w_unused_patsel;

  assign w_unused_patsel = iPatSel;
  assign w_bars          = 1'b0;
  assign w_word          = iSrcValid ? iSrcData : FILL_COLOR;
  assign w_word_missing  = ~iSrcValid;
`endif

  assign oSrcReady = w_in_fill & ~w_bars;

  // A set event in the same cycle as iClr keeps the flag set
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_en        <= 1'b0;
      r_data      <= '0;
      r_underflow <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_en <= w_in_fill;
      if (w_in_fill) begin
        r_data <= w_word;
      end
      if (w_in_fill && w_word_missing) begin
        r_underflow <= 1'b1;
      end else if (iClr) begin
        r_underflow <= 1'b0;
      end
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (iClr) begin
        r_overrun <= 1'b0;
      end
    end
  end

  assign oEn        = r_en;
  assign oData      = r_data;
  assign oUnderflow = r_underflow;
  assign oOverrun   = r_overrun;

endmodule
